vproc_vreg_rd_seq: RTL and testbench

- Read-side client of the vector register file: converts one "read vector register group" request into a sequence of port-width reads on a single register-file read port.
- Returns the read data as a valid/ready beat stream, in order, with a last flag.
- Sits between the vector unit operand-fetch logic and one register-file read port.
- Register-file read is asynchronous: data for the address driven in cycle N is valid in the same cycle N.

---
 rtl/vproc_vreg_rd_seq.sv | 129 ++++++++++++
 tb/tb_vproc_vreg_rd_seq.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_vreg_rd_seq.sv
// Register-group read sequencer: walks the registers of a vector group chunk by chunk
// on one register-file read port and streams the data out through a 2-entry buffer.
module vproc_vreg_rd_seq #(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned PORT_W = 32,
  localparam int unsigned CHUNKS = VREG_W / PORT_W,
  localparam int unsigned CW     = $clog2(CHUNKS),
  localparam int unsigned ADDR_W = 5 + CW
) (
  input  logic              clk_i,
  input  logic              sync_rst_i,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_vreg_i,
  input  logic [1:0]        req_emul_i,
  output logic [ADDR_W-1:0] rf_rd_addr_o,
  input  logic [PORT_W-1:0] rf_rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PORT_W-1:0] out_data_o,
  output logic              out_last_o
);

  typedef enum logic {StIdle, StRead} state_e;

  state_e                  state_q, state_d;
  logic [4:0]              vreg_q, vreg_d;
  logic [1:0]              emul_q, emul_d;
  logic [2:0]              reg_cnt_q, reg_cnt_d;
  logic [CW-1:0]           chunk_q, chunk_d;
  logic [1:0][PORT_W-1:0]  data_q, data_d;
  logic [1:0]              last_q, last_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [1:0]              cnt_q, cnt_d;

  logic push, pop, is_last, chunk_wrap;

  assign out_valid_o  = (cnt_q != 2'd0);
  assign out_data_o   = out_valid_o ? data_q[rd_ptr_q] : '0;
  assign out_last_o   = out_valid_o ? last_q[rd_ptr_q] : 1'b0;
  assign req_ready_o  = (state_q == StIdle) && !flush_i;
  assign rf_rd_addr_o = (state_q == StRead) ? {5'(vreg_q + {2'b00, reg_cnt_q}), chunk_q} : '0;

  assign pop        = out_valid_o && out_ready_i;
  // A full buffer can still take a beat when its head leaves in the same cycle.
  assign push       = (state_q == StRead) && ((cnt_q != 2'd2) || pop);
  assign chunk_wrap = (chunk_q == CW'(CHUNKS - 1));
  assign is_last    = chunk_wrap && (reg_cnt_q == 3'((4'd1 << emul_q) - 4'd1));

  always_comb begin
    state_d   = state_q;
    vreg_d    = vreg_q;
    emul_d    = emul_q;
    reg_cnt_d = reg_cnt_q;
    chunk_d   = chunk_q;
    data_d    = data_q;
    last_d    = last_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q + 2'(push) - 2'(pop);

    if (state_q == StIdle) begin
      if (req_valid_i) begin
        state_d   = StRead;
        vreg_d    = req_vreg_i;
        emul_d    = req_emul_i;
        reg_cnt_d = '0;
        chunk_d   = '0;
      end
    end else if (push) begin
      if (chunk_wrap) begin
        chunk_d   = '0;
        reg_cnt_d = reg_cnt_q + 3'd1;
      end else begin
        chunk_d = chunk_q + CW'(1);
      end
      if (is_last) begin
        state_d = StIdle;
      end
    end

    if (push) begin
      data_d[wr_ptr_q] = rf_rd_data_i;
      last_d[wr_ptr_q] = is_last;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    if (flush_i) begin
      state_d   = StIdle;
      reg_cnt_d = '0;
      chunk_d   = '0;
      cnt_d     = '0;
      rd_ptr_d  = 1'b0;
      wr_ptr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q   <= StIdle;
      vreg_q    <= '0;
      emul_q    <= '0;
      reg_cnt_q <= '0;
      chunk_q   <= '0;
      data_q    <= '0;
      last_q    <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      vreg_q    <= vreg_d;
      emul_q    <= emul_d;
      reg_cnt_q <= reg_cnt_d;
      chunk_q   <= chunk_d;
      data_q    <= data_d;
      last_q    <= last_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_vproc_vreg_rd_seq.sv
// Bench for vproc_vreg_rd_seq: table-driven group reads, directed corner sequences and
// randomized traffic scored against a beat-list model of the group read.
module tb_vproc_vreg_rd_seq;
  localparam int unsigned VREG_W = 128;
  localparam int unsigned PORT_W = 32;
  localparam int unsigned CHUNKS = VREG_W / PORT_W;
  localparam int unsigned ADDR_W = 5 + $clog2(CHUNKS);

  logic              clk = 1'b0;
  logic              sync_rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [4:0]        req_vreg_i = '0;
  logic [1:0]        req_emul_i = '0;
  logic [ADDR_W-1:0] rf_rd_addr_o;
  logic [PORT_W-1:0] rf_rd_data_i;
  logic              out_valid_o;
  logic              out_ready_i = 1'b1;
  logic [PORT_W-1:0] out_data_o;
  logic              out_last_o;

  // Injective address-to-data map, so a wrong address shows up as wrong data.
  function automatic logic [PORT_W-1:0] rf_fn(input logic [ADDR_W-1:0] a);
    return {8'hA5, 5'd0, a, 5'd0, ~a};
  endfunction

  assign rf_rd_data_i = rf_fn(rf_rd_addr_o);

  vproc_vreg_rd_seq #(.VREG_W(VREG_W), .PORT_W(PORT_W)) dut (
    .clk_i        (clk),
    .sync_rst_i   (sync_rst_i),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_vreg_i   (req_vreg_i),
    .req_emul_i   (req_emul_i),
    .rf_rd_addr_o (rf_rd_addr_o),
    .rf_rd_data_i (rf_rd_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PORT_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    logic [4:0]        vreg;
    logic [1:0]        emul;
    int                beats;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
  } vec_t;

  beat_t             exp_q[$];
  logic [PORT_W-1:0] seen_q[$];
  vec_t              vecs[5];

  int          n_chk = 0;
  int          n_pass = 0;
  int          beats_seen = 0;
  int          lasts_seen = 0;
  int          ready_mode = 0;
  int          pat_idx = 0;
  int          b0, l0;
  bit          acc = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Sample at the falling edge: scoreboard pops, stability and idle-zero checks.
  task automatic sample();
    beat_t b;
    @(negedge clk);
    acc = req_valid_i && req_ready_o;
    if (prev_stall) begin
      chk("hold_valid", 32'(out_valid_o), 32'd1);
      chk("hold_data", out_data_o, prev_data);
      chk("hold_last", 32'(out_last_o), 32'(prev_last));
    end
    if (out_valid_o === 1'b0) begin
      chk("idle_data", out_data_o, 32'd0);
      chk("idle_last", 32'(out_last_o), 32'd0);
    end
    if (out_valid_o && out_ready_i && !sync_rst_i) begin
      beats_seen++;
      if (out_last_o) lasts_seen++;
      seen_q.push_back(out_data_o);
      chk("beat_expected", 32'(out_valid_o), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        chk("beat_data", out_data_o, b.data);
        chk("beat_last", 32'(out_last_o), 32'(b.last));
      end
    end
    prev_stall = out_valid_o && !out_ready_i && !flush_i && !sync_rst_i;
    prev_data  = out_data_o;
    prev_last  = out_last_o;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (ready_mode == 1) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
    end else if (ready_mode == 2) begin
      out_ready_i = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
      pat_idx++;
    end
  endtask

  task automatic cycle();
    sample();
    adv();
  endtask

  // Model: a group is registers vreg..vreg+2^emul-1 (mod 32), each read chunk 0..CHUNKS-1.
  task automatic push_model(input int v, input int e);
    logic [ADDR_W-1:0] a;
    for (int r = 0; r < (1 << e); r++) begin
      for (int c = 0; c < CHUNKS; c++) begin
        a = ADDR_W'((((v + r) % 32) * CHUNKS) + c);
        exp_q.push_back('{data: rf_fn(a), last: (r == (1 << e) - 1) && (c == CHUNKS - 1)});
      end
    end
  endtask

  task automatic send_req(input int v, input int e);
    req_valid_i = 1'b1;
    req_vreg_i  = 5'(v);
    req_emul_i  = 2'(e);
    for (int i = 0; i < 300; i++) begin
      sample();
      if (acc) begin
        push_model(v, e);
        adv();
        req_valid_i = 1'b0;
        return;
      end
      adv();
    end
    req_valid_i = 1'b0;
    timeout("req_accept");
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !out_valid_o) return;
      cycle();
    end
    timeout("drain");
  endtask

  initial begin
    vecs[0] = '{vreg: 5'd5,  emul: 2'd0, beats: 4,  first_addr: 7'h14, last_addr: 7'h17};
    vecs[1] = '{vreg: 5'd30, emul: 2'd2, beats: 16, first_addr: 7'h78, last_addr: 7'h07};
    vecs[2] = '{vreg: 5'd0,  emul: 2'd1, beats: 8,  first_addr: 7'h00, last_addr: 7'h07};
    vecs[3] = '{vreg: 5'd31, emul: 2'd3, beats: 32, first_addr: 7'h7C, last_addr: 7'h1B};
    vecs[4] = '{vreg: 5'd17, emul: 2'd1, beats: 8,  first_addr: 7'h44, last_addr: 7'h4B};

    // Reset state
    cycle();
    sample();
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out_last", 32'(out_last_o), 32'd0);
    chk("rst_out_data", out_data_o, 32'd0);
    chk("rst_rf_addr", 32'(rf_rd_addr_o), 32'd0);
    adv();
    sync_rst_i = 1'b0;

    // Single register, cycle-exact timing
    out_ready_i = 1'b1;
    b0 = beats_seen;
    l0 = lasts_seen;
    req_valid_i = 1'b1;
    req_vreg_i  = 5'd5;
    req_emul_i  = 2'd0;
    sample();
    chk("t1_accept", 32'(req_ready_o), 32'd1);
    if (acc) push_model(5, 0);
    adv();
    req_valid_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sample();
      chk("t1_rf_addr", 32'(rf_rd_addr_o), 32'(8'h13 + i));
      chk("t1_req_ready", 32'(req_ready_o), 32'd0);
      chk("t1_out_valid", 32'(out_valid_o), 32'(i >= 2));
      adv();
    end
    sample();
    chk("t1_ready_again", 32'(req_ready_o), 32'd1);
    chk("t1_rf_addr_idle", 32'(rf_rd_addr_o), 32'd0);
    adv();
    drain();
    chk("t1_beats", 32'(beats_seen - b0), 32'd4);
    chk("t1_lasts", 32'(lasts_seen - l0), 32'd1);

    // Table-driven groups, streaming
    foreach (vecs[k]) begin
      b0 = beats_seen;
      l0 = lasts_seen;
      seen_q.delete();
      send_req(int'(vecs[k].vreg), int'(vecs[k].emul));
      drain();
      chk("vec_beats", 32'(beats_seen - b0), 32'(vecs[k].beats));
      chk("vec_lasts", 32'(lasts_seen - l0), 32'd1);
      if (seen_q.size() != 0) begin
        chk("vec_first", seen_q[0], rf_fn(vecs[k].first_addr));
        chk("vec_final", seen_q[$], rf_fn(vecs[k].last_addr));
      end
    end

    // Backpressure 1,0,0,1 pattern
    ready_mode = 2;
    pat_idx    = 0;
    b0 = beats_seen;
    send_req(0, 1);
    drain();
    chk("bp_beats", 32'(beats_seen - b0), 32'd8);
    ready_mode  = 0;
    out_ready_i = 1'b1;

    // Back-to-back requests
    b0 = beats_seen;
    l0 = lasts_seen;
    send_req(2, 0);
    send_req(9, 0);
    drain();
    chk("b2b_beats", 32'(beats_seen - b0), 32'd8);
    chk("b2b_lasts", 32'(lasts_seen - l0), 32'd2);

    // Flush mid-group with two beats buffered and a competing request
    b0 = beats_seen;
    send_req(10, 3);
    for (int i = 0; i < 100 && (beats_seen - b0) < 5; i++) cycle();
    out_ready_i = 1'b0;
    cycle();
    cycle();
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    req_vreg_i  = 5'd20;
    sample();
    chk("fl_req_blocked", 32'(req_ready_o), 32'd0);
    chk("fl_buffered", 32'(out_valid_o), 32'd1);
    adv();
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    exp_q.delete();
    sample();
    chk("fl_out_valid", 32'(out_valid_o), 32'd0);
    chk("fl_req_ready", 32'(req_ready_o), 32'd1);
    adv();
    out_ready_i = 1'b1;
    b0 = beats_seen;
    l0 = lasts_seen;
    seen_q.delete();
    send_req(1, 0);
    drain();
    chk("fl_new_beats", 32'(beats_seen - b0), 32'd4);
    chk("fl_new_lasts", 32'(lasts_seen - l0), 32'd1);
    if (seen_q.size() != 0) chk("fl_new_first", seen_q[0], rf_fn(7'h04));

    // Reset with flush during a stalled read and a full buffer
    out_ready_i = 1'b0;
    send_req(3, 3);
    for (int i = 0; i < 4; i++) cycle();
    sync_rst_i = 1'b1;
    flush_i    = 1'b1;
    sample();
    adv();
    sync_rst_i = 1'b0;
    flush_i    = 1'b0;
    exp_q.delete();
    sample();
    chk("rr_req_ready", 32'(req_ready_o), 32'd1);
    chk("rr_out_valid", 32'(out_valid_o), 32'd0);
    chk("rr_out_last", 32'(out_last_o), 32'd0);
    chk("rr_out_data", out_data_o, 32'd0);
    chk("rr_rf_addr", 32'(rf_rd_addr_o), 32'd0);
    adv();
    out_ready_i = 1'b1;
    b0 = beats_seen;
    seen_q.delete();
    send_req(7, 0);
    drain();
    chk("rr_new_beats", 32'(beats_seen - b0), 32'd4);
    if (seen_q.size() != 0) chk("rr_new_first", seen_q[0], rf_fn(7'h1C));

    // Randomized traffic with random backpressure
    ready_mode = 1;
    b0 = beats_seen;
    l0 = 0;
    for (int n = 0; n < 25; n++) begin
      int v, e;
      v = $urandom_range(0, 31);
      e = $urandom_range(0, 3);
      l0 += CHUNKS << e;
      send_req(v, e);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    chk("rand_beats", 32'(beats_seen - b0), 32'(l0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
